uart_host_bridge: RTL and testbench
===================================

UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

Interface
REQ-001 SHALL have parameter width, default 8, data word width in bits.
REQ-002 SHALL have parameter address_width, default 8, bus address width.
REQ-003 SHALL have parameters rx_address (default 3), tx_address (default 4) and status_address (default 5), the peripheral register map.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port active_address, output, address_width bits: bus address driven to the peripheral.
REQ-007 SHALL have port read_enable, output, 1 bit: the peripheral samples data_in at active_address this cycle.
REQ-008 SHALL have port write_enable, output, 1 bit: the peripheral drives data_out from active_address, valid on the next cycle.
REQ-009 SHALL have port data_in, output, width bits: write data to the peripheral.
REQ-010 SHALL have port data_out, input, width bits: read data from the peripheral.
REQ-011 SHALL have ports tx_data (input, width bits), tx_valid (input, 1 bit) and tx_ready (output, 1 bit): the byte stream to transmit.
REQ-012 SHALL have ports rx_data (output, width bits), rx_valid (output, 1 bit) and rx_ready (input, 1 bit): the received byte stream.

Function
REQ-013 SHALL decode status bit 0 as tx_busy and status bit 1 as rx_available; other bits are ignored.
REQ-014 SHALL hold one tx byte in a tx holding register; tx_ready = holding register empty; accept a byte on tx_valid && tx_ready.
REQ-015 SHALL hold one rx byte in an rx holding register; rx_valid = holding register full; pop it on rx_valid && rx_ready; rx_data stays stable while rx_valid is high.
REQ-016 SHALL implement these FSM states: IDLE, POLL_REQ, POLL_WAIT, RX_REQ, RX_WAIT, TX_WRITE.
REQ-017 SHALL move IDLE -> POLL_REQ unconditionally on the cycle after reset release.
REQ-018 In POLL_REQ, SHALL drive active_address = status_address and write_enable = 1, then go to POLL_WAIT.
REQ-019 In POLL_WAIT, SHALL sample data_out, then go to RX_REQ if rx_available and the rx holding register is empty; otherwise to TX_WRITE if the tx holding register is full and tx_busy = 0; otherwise to POLL_REQ.
REQ-020 In RX_REQ, SHALL drive active_address = rx_address and write_enable = 1; in RX_WAIT, SHALL load data_out into the rx holding register, then go to POLL_REQ.
REQ-021 In TX_WRITE, SHALL drive active_address = tx_address, read_enable = 1 and data_in = the tx holding byte for exactly 1 cycle, mark the holding register empty, then go to POLL_REQ.
REQ-022 SHALL give rx priority over tx when both are eligible in the same POLL_WAIT.
REQ-023 SHALL never assert read_enable and write_enable together; each is a 1-cycle pulse.
REQ-024 SHALL drive active_address = 0, data_in = 0 and both enables low in every other state.
REQ-025 SHALL accept a same-cycle tx accept in TX_WRITE (holding register empties and refills) and a same-cycle rx pop in RX_WAIT (holding register pops and reloads).
REQ-026 Latency: a byte accepted on tx in cycle N SHALL appear on the bus no later than N+4 when the peripheral reports tx_busy = 0.

Reset
REQ-027 On reset, the FSM SHALL be IDLE, both holding registers SHALL be empty, tx_ready = 0 during reset then 1, rx_valid = 0, rx_data = 0, and all bus outputs SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction with no enable pulse on the following cycle and SHALL discard held bytes.

Structure
REQ-029 SHALL take the state enum, status bit indices and default addresses from the shared package buff_uart_pkg.
REQ-030 SHALL place both holding registers inline; no sub-module is required.

Verification
REQ-031 Status 0x00, tx byte 0x0A -> TX_WRITE pulse with address 4 and data_in 0x0A; tx_ready returns high.
REQ-032 Status 0x01 held for 3 polls, then 0x00 -> no TX_WRITE during the busy polls, then exactly one write.
REQ-033 Status 0x02, data_out 0x3E -> RX_REQ on address 3; rx_valid = 1, rx_data = 0x3E until rx_ready.
REQ-034 Status 0x03 with a pending tx -> RX read first, TX write on the following poll.
REQ-035 rx holding register full, rx_ready = 0, status 0x02 -> no RX_REQ until rx_ready pops the byte.
REQ-036 Reset asserted during RX_WAIT -> all outputs 0 next cycle, rx_valid = 0, FSM restarts with POLL_REQ.

Source files
------------

// File: rtl/buff_uart_pkg.sv
// Purpose : shared definitions for the polled UART host bridge (FSM states,
//           status-register bit positions, default register map).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package buff_uart_pkg;

    // Bridge sequencer states. IDLE is only ever seen for the single cycle
    // following reset release.
    typedef enum logic [2:0] {
        IDLE,
        POLL_REQ,
        POLL_WAIT,
        RX_REQ,
        RX_WAIT,
        TX_WRITE
    } bridge_state_t;

    // Peripheral status register layout; all other bits are don't-care.
    localparam int unsigned STATUS_TX_BUSY_BIT  = 0;
    localparam int unsigned STATUS_RX_AVAIL_BIT = 1;

    // Default peripheral register map.
    localparam int unsigned DEFAULT_RX_ADDRESS     = 3;
    localparam int unsigned DEFAULT_TX_ADDRESS     = 4;
    localparam int unsigned DEFAULT_STATUS_ADDRESS = 5;

endpackage

// File: rtl/uart_host_bridge.sv
// Purpose : polls a memory-mapped UART peripheral and bridges it to a pair of
//           valid/ready byte streams (one tx holding byte, one rx holding byte).
// Latency : a tx byte reaches the bus within 4 cycles of acceptance when the
//           peripheral is not busy; an rx byte shows on rx_valid 2 cycles after
//           its read request.
// Backpressure: tx_ready drops while the tx holding byte is waiting; a full rx
//           holding byte (rx_ready low) stops further peripheral rx reads.
//
// Ports:
//   clock, reset            single rising-edge clock, synchronous active-high reset
//   active_address          bus address driven to the peripheral
//   read_enable             peripheral samples data_in at active_address
//   write_enable            peripheral drives data_out next cycle
//   data_in / data_out      bus write data / bus read data
//   tx_data/valid/ready     inbound byte stream to transmit
//   rx_data/valid/ready     outbound stream of received bytes
module uart_host_bridge
    import buff_uart_pkg::*;
#(
    parameter int unsigned width          = 8,
    parameter int unsigned address_width  = 8,
    parameter int unsigned rx_address     = DEFAULT_RX_ADDRESS,
    parameter int unsigned tx_address     = DEFAULT_TX_ADDRESS,
    parameter int unsigned status_address = DEFAULT_STATUS_ADDRESS
) (
    input  logic                     clock,
    input  logic                     reset,

    output logic [address_width-1:0] active_address,
    output logic                     read_enable,
    output logic                     write_enable,
    output logic [width-1:0]         data_in,
    input  logic [width-1:0]         data_out,

    input  logic [width-1:0]         tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,

    output logic [width-1:0]         rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready
);

    localparam logic [address_width-1:0] RX_ADDR     = address_width'(rx_address);
    localparam logic [address_width-1:0] TX_ADDR     = address_width'(tx_address);
    localparam logic [address_width-1:0] STATUS_ADDR = address_width'(status_address);

    bridge_state_t            r_state;
    logic [address_width-1:0] r_active_address;
    logic                     r_read_enable;
    logic                     r_write_enable;
    logic [width-1:0]         r_data_in;

    logic [width-1:0]         r_tx_hold;
    logic                     r_tx_full;
    logic [width-1:0]         r_rx_hold;
    logic                     r_rx_full;

    logic                     w_tx_accept;
    logic                     w_rx_pop;
    logic                     w_tx_busy;
    logic                     w_rx_available;

    // The tx holding byte is consumed during TX_WRITE, so a new byte may be
    // taken in that same cycle. Ready is forced low while reset is held.
    assign tx_ready    = ~reset & (~r_tx_full | (r_state == TX_WRITE));
    assign w_tx_accept = tx_valid & tx_ready;

    assign rx_valid    = r_rx_full;
    assign rx_data     = r_rx_hold;
    assign w_rx_pop    = r_rx_full & rx_ready;

    // Only meaningful in POLL_WAIT, when data_out carries the status register.
    assign w_tx_busy      = data_out[STATUS_TX_BUSY_BIT];
    assign w_rx_available = data_out[STATUS_RX_AVAIL_BIT];

    assign active_address = r_active_address;
    assign read_enable    = r_read_enable;
    assign write_enable   = r_write_enable;
    assign data_in        = r_data_in;

    // Bus outputs are registered: each transition loads the outputs that the
    // destination state presents. Anything not loaded returns to zero, which
    // makes every enable a single-cycle pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= IDLE;
            r_active_address <= '0;
            r_read_enable    <= 1'b0;
            r_write_enable   <= 1'b0;
            r_data_in        <= '0;
            r_tx_hold        <= '0;
            r_tx_full        <= 1'b0;
            r_rx_hold        <= '0;
            r_rx_full        <= 1'b0;
        end else begin
            r_active_address <= '0;
            r_read_enable    <= 1'b0;
            r_write_enable   <= 1'b0;
            r_data_in        <= '0;

            // tx holding register: refill wins over the TX_WRITE drain.
            if (w_tx_accept) begin
                r_tx_hold <= tx_data;
                r_tx_full <= 1'b1;
            end else if (r_state == TX_WRITE) begin
                r_tx_full <= 1'b0;
            end

            // rx holding register pop; a load in RX_WAIT below overrides it.
            if (w_rx_pop) begin
                r_rx_full <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_state          <= POLL_REQ;
                    r_active_address <= STATUS_ADDR;
                    r_write_enable   <= 1'b1;
                end

                POLL_REQ: begin
                    r_state <= POLL_WAIT;
                end

                POLL_WAIT: begin
                    // rx is checked first so it wins when both are eligible.
                    if (w_rx_available && !r_rx_full) begin
                        r_state          <= RX_REQ;
                        r_active_address <= RX_ADDR;
                        r_write_enable   <= 1'b1;
                    end else if (r_tx_full && !w_tx_busy) begin
                        r_state          <= TX_WRITE;
                        r_active_address <= TX_ADDR;
                        r_read_enable    <= 1'b1;
                        r_data_in        <= r_tx_hold;
                    end else begin
                        r_state          <= POLL_REQ;
                        r_active_address <= STATUS_ADDR;
                        r_write_enable   <= 1'b1;
                    end
                end

                RX_REQ: begin
                    r_state <= RX_WAIT;
                end

                RX_WAIT: begin
                    r_rx_hold        <= data_out;
                    r_rx_full        <= 1'b1;
                    r_state          <= POLL_REQ;
                    r_active_address <= STATUS_ADDR;
                    r_write_enable   <= 1'b1;
                end

                TX_WRITE: begin
                    r_state          <= POLL_REQ;
                    r_active_address <= STATUS_ADDR;
                    r_write_enable   <= 1'b1;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host_bridge.sv
// Purpose : self-checking bench for uart_host_bridge with a behavioural UART
//           peripheral and byte-order scoreboards for both streams.
// Latency : n/a.
// Backpressure: bench drives random tx_valid / rx_ready and peripheral busy.
module tb_uart_host_bridge;

    localparam int RX_A = 3;
    localparam int TX_A = 4;
    localparam int ST_A = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] active_address;
    logic       read_enable;
    logic       write_enable;
    logic [7:0] data_in;
    logic [7:0] data_out = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Peripheral model state and scoreboards.
    logic       per_busy = 1'b0;
    logic       per_junk = 1'b0;
    logic       last_busy = 1'b0;
    logic [7:0] last_tx_data = 8'h00;
    logic [7:0] per_rx_q[$];     // bytes the peripheral still has to hand over
    logic [7:0] delivered[$];    // bytes handed to the bridge, not yet popped
    logic [7:0] exp_tx_q[$];     // bytes accepted on tx, not yet written
    int         ev_log[$];       // 1 = rx read request, 2 = tx write
    int         poll_count = 0;
    int         tx_write_count = 0;
    int         rx_read_count = 0;

    uart_host_bridge #(
        .width(8), .address_width(8),
        .rx_address(RX_A), .tx_address(TX_A), .status_address(ST_A)
    ) dut (
        .clock(clock), .reset(reset),
        .active_address(active_address), .read_enable(read_enable),
        .write_enable(write_enable), .data_in(data_in), .data_out(data_out),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Peripheral: write_enable asks for a register on data_out next cycle,
    // read_enable delivers data_in to the transmitter.
    always @(posedge clock) begin
        if (read_enable && active_address == 8'(TX_A)) begin
            ev_log.push_back(2);
            tx_write_count <= tx_write_count + 1;
            last_tx_data   <= data_in;
            check("tx_write_while_busy", 32'(last_busy), 0);
            if (exp_tx_q.size() == 0)
                check("tx_write_unexpected", 1, 0);
            else
                check("tx_write_data", 32'(data_in), 32'(exp_tx_q.pop_front()));
        end
        if (write_enable && active_address == 8'(ST_A)) begin
            poll_count <= poll_count + 1;
            last_busy  <= per_busy;
            data_out   <= {(per_junk ? 6'($urandom) : 6'd0), (per_rx_q.size() != 0), per_busy};
        end else if (write_enable && active_address == 8'(RX_A)) begin
            ev_log.push_back(1);
            rx_read_count <= rx_read_count + 1;
            if (per_rx_q.size() != 0) begin
                delivered.push_back(per_rx_q[0]);
                data_out <= per_rx_q[0];
                per_rx_q.delete(0);
            end else begin
                delivered.push_back(8'h00);
                data_out <= 8'h00;
            end
        end
    end

    // Bus protocol invariants, sampled away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("enables_exclusive", 32'(read_enable & write_enable), 0);
            if (!read_enable && !write_enable)
                check("bus_quiet", 32'({active_address, data_in}), 0);
            if (read_enable)
                check("tx_write_address", 32'(active_address), TX_A);
            if (write_enable)
                check("read_req_address", 32'((active_address == 8'(RX_A)) || (active_address == 8'(ST_A))), 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_tx(input logic [7:0] b, output int acc_cyc);
        logic ok;
        ok = 1'b0;
        acc_cyc = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                exp_tx_q.push_back(b);
            end
            tick();
        end
        tx_valid = 1'b0;
        check("tx_accepted", 32'(ok), 1);
    endtask

    task automatic recv_rx(input string tag);
        logic ok;
        ok = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (rx_valid) begin
                ok = 1'b1;
                if (delivered.size() == 0)
                    check({tag, "_unexpected"}, 1, 0);
                else
                    check(tag, 32'(rx_data), 32'(delivered.pop_front()));
            end
            tick();
        end
        rx_ready = 1'b0;
        check({tag, "_seen"}, 32'(ok), 1);
    endtask

    initial begin
        int  acc_cyc;
        int  p0;
        int  w0;
        int  e0;
        int  r0;
        int  pops;
        int  accepts;
        logic found;
        logic acc;

        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_address",  32'(active_address), 0);
        check("rst_re",       32'(read_enable), 0);
        check("rst_we",       32'(write_enable), 0);
        check("rst_data_in",  32'(data_in), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data",  32'(rx_data), 0);
        check("rst_tx_ready", 32'(tx_ready), 0);

        reset = 1'b0;
        #1;
        check("tx_ready_after_reset", 32'(tx_ready), 1);
        tick();
        check("first_poll_we",   32'(write_enable), 1);
        check("first_poll_addr", 32'(active_address), ST_A);
        check("first_poll_re",   32'(read_enable), 0);

        // Idle peripheral, one tx byte: written within 4 cycles.
        per_busy = 1'b0;
        send_tx(8'h0A, acc_cyc);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (read_enable) found = 1'b1;
            else tick();
        end
        check("tx_write_seen", 32'(found), 1);
        check("tx_write_addr", 32'(active_address), TX_A);
        check("tx_write_0a",   32'(data_in), 32'h0A);
        check("tx_write_we_low", 32'(write_enable), 0);
        check("tx_latency_le4", 32'((cyc - acc_cyc) <= 4), 1);
        tick();
        check("tx_ready_restored", 32'(tx_ready), 1);

        // Busy for three polls: the byte must wait, then go out exactly once.
        per_busy = 1'b1;
        w0 = tx_write_count;
        send_tx(8'h5B, acc_cyc);
        p0 = poll_count;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = (poll_count >= p0 + 3);
        end
        check("busy_polls_seen", 32'(found), 1);
        check("no_write_while_busy", tx_write_count, w0);
        check("tx_ready_while_held", 32'(tx_ready), 0);
        per_busy = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (tx_write_count == w0 + 1);
        end
        check("write_after_busy", 32'(found), 1);
        repeat (10) tick();
        check("single_write", tx_write_count, w0 + 1);
        check("busy_write_data", 32'(last_tx_data), 32'h5B);

        // rx byte 0x3E: fetched from the rx register, held until popped.
        per_rx_q.push_back(8'h3E);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (write_enable && active_address == 8'(RX_A)) found = 1'b1;
            else tick();
        end
        check("rx_req_seen", 32'(found), 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (rx_valid) found = 1'b1;
            else tick();
        end
        check("rx_valid_set", 32'(found), 1);
        check("rx_data_3e", 32'(rx_data), 32'h3E);
        repeat (5) tick();
        check("rx_valid_held", 32'(rx_valid), 1);
        check("rx_data_stable", 32'(rx_data), 32'h3E);
        recv_rx("rx_pop_3e");
        check("rx_valid_cleared", 32'(rx_valid), 0);

        // rx and tx eligible in the same poll: rx read first, then tx write.
        per_busy = 1'b1;
        send_tx(8'h77, acc_cyc);
        p0 = poll_count;
        for (int i = 0; i < 20 && poll_count < p0 + 2; i++) tick();
        e0 = ev_log.size();
        per_busy = 1'b0;
        per_rx_q.push_back(8'hC5);
        for (int i = 0; i < 60 && ev_log.size() < e0 + 2; i++) tick();
        check("prio_events", 32'(ev_log.size() >= e0 + 2), 1);
        if (ev_log.size() >= e0 + 2) begin
            check("prio_rx_first",  ev_log[e0], 1);
            check("prio_tx_second", ev_log[e0 + 1], 2);
        end
        check("prio_tx_data", 32'(last_tx_data), 32'h77);
        recv_rx("rx_pop_c5");

        // Full rx holding byte blocks further rx reads until popped.
        per_rx_q.push_back(8'h11);
        for (int i = 0; i < 30 && !rx_valid; i++) tick();
        check("hold_full", 32'(rx_valid), 1);
        r0 = rx_read_count;
        per_rx_q.push_back(8'h22);
        repeat (12) tick();
        check("no_rx_req_when_full", rx_read_count, r0);
        check("held_byte_11", 32'(rx_data), 32'h11);
        recv_rx("rx_pop_11");
        recv_rx("rx_pop_22");
        check("rx_req_after_pop", rx_read_count, r0 + 1);

        // Reset in RX_WAIT aborts the read and drops held bytes.
        per_rx_q.push_back(8'h99);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (write_enable && active_address == 8'(RX_A)) found = 1'b1;
            else tick();
        end
        check("abort_rx_req_seen", 32'(found), 1);
        tick();
        reset = 1'b1;
        tick();
        check("abort_address",  32'(active_address), 0);
        check("abort_enables",  32'({read_enable, write_enable}), 0);
        check("abort_data_in",  32'(data_in), 0);
        check("abort_rx_valid", 32'(rx_valid), 0);
        check("abort_rx_data",  32'(rx_data), 0);
        check("abort_tx_ready", 32'(tx_ready), 0);
        delivered.delete();
        exp_tx_q.delete();
        reset = 1'b0;
        tick();
        check("restart_poll_we",   32'(write_enable), 1);
        check("restart_poll_addr", 32'(active_address), ST_A);
        check("restart_rx_valid",  32'(rx_valid), 0);

        // Random traffic: both streams must carry every byte once, in order.
        per_junk = 1'b1;
        pops = 0;
        accepts = 0;
        for (int c = 0; c < 3000; c++) begin
            per_busy = ($urandom_range(0, 3) == 0);
            if (per_rx_q.size() < 4 && $urandom_range(0, 5) == 0)
                per_rx_q.push_back(8'($urandom));
            if (!tx_valid && $urandom_range(0, 2) == 0) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
            end
            rx_ready = 1'($urandom_range(0, 1));
            if (rx_valid && rx_ready) begin
                pops++;
                if (delivered.size() == 0) check("rnd_rx_unexpected", 1, 0);
                else check("rnd_rx_data", 32'(rx_data), 32'(delivered.pop_front()));
            end
            acc = tx_valid && tx_ready;
            if (acc) begin
                exp_tx_q.push_back(tx_data);
                accepts++;
            end
            tick();
            if (acc) tx_valid = 1'b0;
        end

        // Drain everything outstanding.
        tx_valid = 1'b0;
        per_busy = 1'b0;
        per_junk = 1'b0;
        rx_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (exp_tx_q.size() == 0 && per_rx_q.size() == 0 && delivered.size() == 0 && !rx_valid)
                break;
            if (rx_valid) begin
                pops++;
                if (delivered.size() == 0) check("drain_rx_unexpected", 1, 0);
                else check("drain_rx_data", 32'(rx_data), 32'(delivered.pop_front()));
            end
            tick();
        end
        rx_ready = 1'b0;
        check("drain_tx_empty",    exp_tx_q.size(), 0);
        check("drain_per_rx_empty", per_rx_q.size(), 0);
        check("drain_rx_empty",    delivered.size(), 0);
        check("rnd_had_tx", 32'(accepts > 20), 1);
        check("rnd_had_rx", 32'(pops > 20), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
